uart_rx_frame_ctrl: RTL and testbench
=====================================

# uart_rx_frame_ctrl

Frame controller that sits directly behind the UART receiver and sequences its byte stream into validated packets. It hunts for a sync byte, takes a length byte, buffers up to MAX_LEN payload bytes and checks an 8-bit additive checksum. Verified payloads are replayed to downstream logic over a valid/ready stream. Malformed frames, stalled frames and bytes arriving while a frame is being delivered are flagged with one-cycle error pulses.

## Interface
- SYNC_BYTE, 8'hA5, start-of-frame marker
- MAX_LEN, 16, maximum payload bytes (1..255); sizes the payload buffer
- TIMEOUT_CLKS, 1740, idle clocks allowed between bytes inside a frame (20 bit times at 87 clks/bit)

- i_Clock  in  1  system clock
- i_Reset  in  1  reset, synchronous, active-high
- i_RX_DV  in  1  one-cycle strobe from the UART receiver: byte valid
- i_RX_Byte  in  8  received byte, qualified by i_RX_DV
- o_Frame_Valid  out  1  payload byte available
- o_Frame_Byte  out  8  payload byte
- o_Frame_Last  out  1  final payload byte of the frame, qualified by o_Frame_Valid
- i_Frame_Ready  in  1  downstream accepts the byte when o_Frame_Valid && i_Frame_Ready
- o_Frame_Len  out  8  LEN of the frame being delivered; held until the next frame
- o_CRC_Err  out  1  pulse: checksum mismatch
- o_Len_Err  out  1  pulse: LEN == 0 or LEN > MAX_LEN
- o_Timeout_Err  out  1  pulse: inter-byte timeout
- o_Overrun  out  1  pulse: byte dropped during DELIVER
- o_Busy  out  1  state != IDLE

## Operation
- Frame format: SYNC_BYTE, LEN, then LEN payload bytes, then CSUM.
- A frame is good when (LEN + Σpayload + CSUM) mod 256 == 0. The 8-bit accumulator wraps.
- States and transitions:
  - IDLE: a byte equal to SYNC_BYTE moves to GET_LEN. All other bytes are ignored silently.
  - GET_LEN: LEN in 1..MAX_LEN stores LEN, loads the accumulator with LEN, clears the write index and moves to GET_DATA. Otherwise pulse o_Len_Err and go to IDLE.
  - GET_DATA: each byte is written to buf[wr_idx] and added to the accumulator. After the LENth byte, go to GET_CSUM.
  - GET_CSUM: if (acc + byte) mod 256 == 0, update o_Frame_Len, clear the read index and go to DELIVER. Otherwise pulse o_CRC_Err and go to IDLE.
  - DELIVER: o_Frame_Valid = 1 and o_Frame_Byte = buf[rd_idx]. o_Frame_Last = 1 when rd_idx == LEN-1. Each handshake advances rd_idx. The handshake on the last byte returns to IDLE.
- Timeout counter:
  - Cleared on every accepted i_RX_DV and on entry to GET_LEN.
  - Increments each cycle in GET_LEN, GET_DATA and GET_CSUM.
  - When it reaches TIMEOUT_CLKS-1 with no i_RX_DV that cycle: pulse o_Timeout_Err and go to IDLE.
  - If i_RX_DV coincides with the terminal count, the byte wins and the counter clears.
- DELIVER takes no input. Any i_RX_DV while in DELIVER pulses o_Overrun, and the byte is discarded, even if it equals SYNC_BYTE.
- Outputs remain stable while o_Frame_Valid && !i_Frame_Ready.
- i_Reset at any point:
  - State goes to IDLE; the partial frame is discarded with no error pulse.
  - All outputs go to 0, including o_Frame_Len.
  - Buffer contents are not reset.
- At most one error pulse is asserted per cycle.

## Timing
- All outputs are registered.
- Error pulses are high for exactly one cycle, the cycle after the clock edge that sampled the offending byte or terminal count.
- o_Frame_Valid rises in the cycle after the edge that sampled a good CSUM, so first payload latency is 1 clock from CSUM.
- With i_Frame_Ready held high, payload streams 1 byte per clock; a LEN-byte frame occupies DELIVER for LEN cycles.
- After the last handshake, o_Frame_Valid and o_Busy are 0 in the next cycle. A SYNC byte is accepted from that cycle onward.
- Timeout: o_Timeout_Err is high in cycle TIMEOUT_CLKS after the edge that sampled the last in-frame byte.

## Test plan
- Good frame A5 03 11 22 33 97 with ready=1: outputs 11, 22, 33 on three consecutive cycles, o_Frame_Last only with 33, o_Frame_Len=3, no error pulses.
- Bytes 00 FF 5A, then A5 01 7E 81: leading bytes ignored; single output 7E with Last=1.
- Bad checksum A5 03 11 22 33 98: exactly one o_CRC_Err pulse, o_Frame_Valid never asserts, o_Busy=0 afterwards. The next good frame delivers normally.
- LEN errors A5 00 and A5 11 (17 > MAX_LEN): one o_Len_Err pulse each, return to IDLE. A following LEN=16 frame with correct CSUM delivers all 16 bytes.
- Timeout: A5 02 11 then silence gives o_Timeout_Err exactly 1740 cycles after the 11 byte. A repeat with a byte arriving on the terminal cycle gives no error and the frame completes.
- Backpressure and reset:
  - Toggle i_Frame_Ready 1010… during a 3-byte frame: byte and Last hold while ready=0, and all bytes are delivered in order. Inject i_RX_DV during DELIVER: one o_Overrun pulse, output stream unchanged.
  - Assert i_Reset mid-payload: all outputs 0 next cycle, no error pulse. The next good frame delivers correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-in / payload-out bundle for the UART frame controller.
// slave faces the controller, master faces the source and sink.
interface uart_rx_frame_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_Frame_Valid;
  logic [7:0] o_Frame_Byte;
  logic       o_Frame_Last;
  logic       i_Frame_Ready;
  logic [7:0] o_Frame_Len;
  logic       o_CRC_Err;
  logic       o_Len_Err;
  logic       o_Timeout_Err;
  logic       o_Overrun;
  logic       o_Busy;

  modport slave (
    input  i_RX_DV,
    input  i_RX_Byte,
    input  i_Frame_Ready,
    output o_Frame_Valid,
    output o_Frame_Byte,
    output o_Frame_Last,
    output o_Frame_Len,
    output o_CRC_Err,
    output o_Len_Err,
    output o_Timeout_Err,
    output o_Overrun,
    output o_Busy
  );

  modport master (
    output i_RX_DV,
    output i_RX_Byte,
    output i_Frame_Ready,
    input  o_Frame_Valid,
    input  o_Frame_Byte,
    input  o_Frame_Last,
    input  o_Frame_Len,
    input  o_CRC_Err,
    input  o_Len_Err,
    input  o_Timeout_Err,
    input  o_Overrun,
    input  o_Busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Sync/len/payload/checksum framer behind a UART receiver;
// buffers a verified payload and replays it on a valid/ready stream.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 1740
) (
  input logic                 i_Clock,
  input logic                 i_Reset,
  uart_rx_frame_ctrl_if.slave bus
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_LEN,
    S_GET_DATA,
    S_GET_CSUM,
    S_DELIVER
  } state_t;

  state_t        r_state;
  state_t        w_state;
  logic [7:0]    r_len;
  logic [7:0]    w_len;
  logic [7:0]    r_acc;
  logic [7:0]    w_acc;
  logic [7:0]    r_wr_idx;
  logic [7:0]    w_wr_idx;
  logic [7:0]    r_rd_idx;
  logic [7:0]    w_rd_idx;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo;
  logic [7:0]    r_buf [MAX_LEN];
  logic          w_we;

  logic       r_valid;
  logic [7:0] r_byte;
  logic       r_last;
  logic [7:0] r_frame_len;
  logic [7:0] w_frame_len;
  logic       r_crc_err;
  logic       w_crc_err;
  logic       r_len_err;
  logic       w_len_err;
  logic       r_tmo_err;
  logic       w_tmo_err;
  logic       r_overrun;
  logic       w_overrun;
  logic       r_busy;

  logic       w_dv;
  logic [7:0] w_rx;
  logic       w_hs;
  logic       w_in_frame;
  logic       w_deliver;

  assign w_dv       = bus.i_RX_DV;
  assign w_rx       = bus.i_RX_Byte;
  assign w_hs       = r_valid && bus.i_Frame_Ready;
  assign w_in_frame = (r_state == S_GET_LEN) ||
                      (r_state == S_GET_DATA) ||
                      (r_state == S_GET_CSUM);
  assign w_deliver  = (w_state == S_DELIVER);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_len       = r_len;
    w_acc       = r_acc;
    w_wr_idx    = r_wr_idx;
    w_rd_idx    = r_rd_idx;
    w_tmo       = r_tmo;
    w_we        = 1'b0;
    w_frame_len = r_frame_len;
    w_crc_err   = 1'b0;
    w_len_err   = 1'b0;
    w_tmo_err   = 1'b0;
    w_overrun   = 1'b0;

    // A byte on the terminal count cycle wins over the timeout.
    if (w_in_frame && !w_dv) begin
      if (r_tmo == TMO_LAST) begin
        w_tmo_err = 1'b1;
        w_state   = S_IDLE;
      end else begin
        w_tmo = r_tmo + TMO_ONE;
      end
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_dv && (w_rx == SYNC_BYTE)) begin
          w_state = S_GET_LEN;
          w_tmo   = '0;
        end
      end
      S_GET_LEN: begin
        if (w_dv) begin
          w_tmo = '0;
          if ((w_rx != 8'd0) && (w_rx <= LEN_MAX)) begin
            w_len    = w_rx;
            w_acc    = w_rx;
            w_wr_idx = 8'd0;
            w_state  = S_GET_DATA;
          end else begin
            w_len_err = 1'b1;
            w_state   = S_IDLE;
          end
        end
      end
      S_GET_DATA: begin
        if (w_dv) begin
          w_tmo    = '0;
          w_we     = 1'b1;
          w_acc    = r_acc + w_rx;
          w_wr_idx = r_wr_idx + 8'd1;
          if (r_wr_idx == (r_len - 8'd1)) begin
            w_state = S_GET_CSUM;
          end
        end
      end
      S_GET_CSUM: begin
        if (w_dv) begin
          w_tmo = '0;
          if (8'(r_acc + w_rx) == 8'd0) begin
            w_frame_len = r_len;
            w_rd_idx    = 8'd0;
            w_state     = S_DELIVER;
          end else begin
            w_crc_err = 1'b1;
            w_state   = S_IDLE;
          end
        end
      end
      S_DELIVER: begin
        w_overrun = w_dv;
        if (w_hs) begin
          if (r_rd_idx == (r_len - 8'd1)) begin
            w_state = S_IDLE;
          end else begin
            w_rd_idx = r_rd_idx + 8'd1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_len       <= 8'd0;
      r_acc       <= 8'd0;
      r_wr_idx    <= 8'd0;
      r_rd_idx    <= 8'd0;
      r_tmo       <= '0;
      r_valid     <= 1'b0;
      r_byte      <= 8'd0;
      r_last      <= 1'b0;
      r_frame_len <= 8'd0;
      r_crc_err   <= 1'b0;
      r_len_err   <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_len       <= w_len;
      r_acc       <= w_acc;
      r_wr_idx    <= w_wr_idx;
      r_rd_idx    <= w_rd_idx;
      r_tmo       <= w_tmo;
      r_valid     <= w_deliver;
      r_byte      <= w_deliver ? r_buf[w_rd_idx[IW-1:0]] : 8'd0;
      r_last      <= w_deliver && (w_rd_idx == (w_len - 8'd1));
      r_frame_len <= w_frame_len;
      r_crc_err   <= w_crc_err;
      r_len_err   <= w_len_err;
      r_tmo_err   <= w_tmo_err;
      r_overrun   <= w_overrun;
      r_busy      <= (w_state != S_IDLE);
    end
  end

  // Payload storage keeps its contents across reset.
  always_ff @(posedge i_Clock) begin
    if (w_we && !i_Reset) begin
      r_buf[r_wr_idx[IW-1:0]] <= w_rx;
    end
  end

  assign bus.o_Frame_Valid = r_valid;
  assign bus.o_Frame_Byte  = r_byte;
  assign bus.o_Frame_Last  = r_last;
  assign bus.o_Frame_Len   = r_frame_len;
  assign bus.o_CRC_Err     = r_crc_err;
  assign bus.o_Len_Err     = r_len_err;
  assign bus.o_Timeout_Err = r_tmo_err;
  assign bus.o_Overrun     = r_overrun;
  assign bus.o_Busy        = r_busy;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: directed frames in,
// expected payload and error pulses queued and checked by a monitor.
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if bus ();

  uart_rx_frame_ctrl dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [7:0] len;
  } exp_t;

  localparam logic [3:0] E_CRC = 4'b1000;
  localparam logic [3:0] E_LEN = 4'b0100;
  localparam logic [3:0] E_TMO = 4'b0010;
  localparam logic [3:0] E_OVR = 4'b0001;

  exp_t       exp_q [$];
  logic [3:0] err_q [$];
  int checks = 0;
  int errors = 0;

  logic       hold_chk = 1'b0;
  logic [7:0] p_byte;
  logic       p_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: compares every handshake and every error pulse.
  always @(negedge clk) begin
    logic [3:0] e;
    exp_t x;
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_byte", {24'd0, bus.o_Frame_Byte}, {24'd0, p_byte});
        chk("hold_last", {31'd0, bus.o_Frame_Last}, {31'd0, p_last});
        chk("hold_valid", {31'd0, bus.o_Frame_Valid}, 32'd1);
      end
      if (bus.o_Frame_Valid && bus.i_Frame_Ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_out got %0h required none",
                   bus.o_Frame_Byte);
        end else begin
          x = exp_q.pop_front();
          chk("out_byte", {24'd0, bus.o_Frame_Byte}, {24'd0, x.b});
          chk("out_last", {31'd0, bus.o_Frame_Last}, {31'd0, x.last});
          chk("out_len", {24'd0, bus.o_Frame_Len}, {24'd0, x.len});
        end
      end
      e = {bus.o_CRC_Err, bus.o_Len_Err, bus.o_Timeout_Err,
           bus.o_Overrun};
      if (e != 4'd0) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_err got %b required none", e);
        end else begin
          chk("err_code", {28'd0, e}, {28'd0, err_q.pop_front()});
        end
      end
      hold_chk = bus.o_Frame_Valid && !bus.i_Frame_Ready;
      p_byte   = bus.o_Frame_Byte;
      p_last   = bus.o_Frame_Last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_RX_DV   = 1'b1;
    bus.i_RX_Byte = b;
    step();
    bus.i_RX_DV   = 1'b0;
  endtask

  task automatic expect_payload(input logic [7:0] pl [$]);
    exp_t x;
    for (int i = 0; i < pl.size(); i++) begin
      x.b    = pl[i];
      x.last = (i == pl.size() - 1);
      x.len  = 8'(pl.size());
      exp_q.push_back(x);
    end
  endtask

  task automatic send_frame(input logic [7:0] pl [$],
                            input logic [7:0] cs, input bit good);
    if (good) expect_payload(pl);
    else err_q.push_back(E_CRC);
    send(8'hA5);
    send(8'(pl.size()));
    foreach (pl[i]) send(pl[i]);
    send(cs);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, {31'd0, bus.o_Frame_Valid}, 32'd0);
    chk({nm, "_byte"}, {24'd0, bus.o_Frame_Byte}, 32'd0);
    chk({nm, "_last"}, {31'd0, bus.o_Frame_Last}, 32'd0);
    chk({nm, "_len"}, {24'd0, bus.o_Frame_Len}, 32'd0);
    chk({nm, "_errs"}, {28'd0, bus.o_CRC_Err, bus.o_Len_Err,
        bus.o_Timeout_Err, bus.o_Overrun}, 32'd0);
    chk({nm, "_busy"}, {31'd0, bus.o_Busy}, 32'd0);
  endtask

  logic [7:0] pa [$];
  logic [7:0] pb [$];
  logic [7:0] p16 [$];
  logic [7:0] s;

  initial begin
    bus.i_RX_DV       = 1'b0;
    bus.i_RX_Byte     = 8'h00;
    bus.i_Frame_Ready = 1'b1;
    pa = '{8'h11, 8'h22, 8'h33};
    pb = '{8'h7E};

    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Good frame, first byte one clock after CSUM, 3 consecutive
    send_frame(pa, 8'h97, 1'b1);
    chk("lat_valid", {31'd0, bus.o_Frame_Valid}, 32'd1);
    chk("lat_byte", {24'd0, bus.o_Frame_Byte}, 32'h11);
    step();
    step();
    chk("third_last", {31'd0, bus.o_Frame_Last}, 32'd1);
    step();
    chk("post_valid", {31'd0, bus.o_Frame_Valid}, 32'd0);
    chk("post_busy", {31'd0, bus.o_Busy}, 32'd0);
    chk("held_len", {24'd0, bus.o_Frame_Len}, 32'd3);

    // Noise before sync is ignored
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    chk("noise_busy", {31'd0, bus.o_Busy}, 32'd0);
    send_frame(pb, 8'h81, 1'b1);
    repeat (3) step();

    // Bad checksum, then recovery
    send_frame(pa, 8'h98, 1'b0);
    chk("crc_busy", {31'd0, bus.o_Busy}, 32'd0);
    chk("crc_pulse", {31'd0, bus.o_CRC_Err}, 32'd1);
    step();
    chk("crc_one_cycle", {31'd0, bus.o_CRC_Err}, 32'd0);
    send_frame(pa, 8'h97, 1'b1);
    repeat (5) step();

    // LEN boundaries: 0 and MAX_LEN+1 rejected, MAX_LEN accepted
    err_q.push_back(E_LEN);
    send(8'hA5);
    send(8'h00);
    err_q.push_back(E_LEN);
    send(8'hA5);
    send(8'h11);
    chk("len_busy", {31'd0, bus.o_Busy}, 32'd0);
    s = 8'd16;
    for (int i = 0; i < 16; i++) begin
      p16.push_back(8'(i * 7 + 3));
      s = s + 8'(i * 7 + 3);
    end
    send_frame(p16, 8'(8'd0 - s), 1'b1);
    repeat (16) step();
    chk("len16_done", {31'd0, bus.o_Busy}, 32'd0);
    chk("len16_len", {24'd0, bus.o_Frame_Len}, 32'd16);

    // Inter-byte timeout fires 1740 edges after the last byte
    err_q.push_back(E_TMO);
    send(8'hA5);
    send(8'h02);
    send(8'h11);
    repeat (1739) step();
    chk("tmo_early", {31'd0, bus.o_Timeout_Err}, 32'd0);
    step();
    chk("tmo_pulse", {31'd0, bus.o_Timeout_Err}, 32'd1);
    chk("tmo_busy", {31'd0, bus.o_Busy}, 32'd0);
    step();

    // Byte landing on the terminal count wins
    expect_payload('{8'h11, 8'h22});
    send(8'hA5);
    send(8'h02);
    send(8'h11);
    repeat (1739) step();
    send(8'h22);
    chk("tmo_race_busy", {31'd0, bus.o_Busy}, 32'd1);
    send(8'hCB);
    repeat (4) step();

    // Backpressure 1010... plus an overrun byte during delivery
    expect_payload('{8'hAA, 8'hBB, 8'hCC});
    send(8'hA5);
    send(8'h03);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hCC);
    err_q.push_back(E_OVR);
    for (int k = 0; k < 8; k++) begin
      bus.i_Frame_Ready = (k % 2 == 0);
      bus.i_RX_DV       = (k == 1);
      bus.i_RX_Byte     = 8'hA5;
      step();
    end
    bus.i_RX_DV       = 1'b0;
    bus.i_Frame_Ready = 1'b1;
    chk("bp_busy", {31'd0, bus.o_Busy}, 32'd0);

    // Reset mid-payload, then a clean frame
    send(8'hA5);
    send(8'h04);
    send(8'h01);
    send(8'h02);
    rst = 1'b1;
    step();
    chk_zero("midrst");
    rst = 1'b0;
    send_frame(pb, 8'h81, 1'b1);
    repeat (4) step();

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("err_q_drained", err_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
